// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    typedef enum logic { RUN, FLUSH } fetch_state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory, redirect and decoder-side signals of the fetch unit.
interface instr_fetch_if;
    logic imem_req;
    logic [31:0] imem_addr;
    logic imem_gnt;
    logic imem_rvalid;
    logic [31:0] imem_rdata;
    logic redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic instr_valid;
    logic instr_ready;
    logic misalign;
    modport master (
        output imem_req, imem_addr, instr, pc, instr_valid, misalign,
        input imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input imem_req, imem_addr, instr, pc, instr_valid, misalign,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic flush,
    input fetch_entry_t din,
    output fetch_entry_t dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH + 1) - 1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout = mem[rd_ptr];
    assign empty = count == '0;
    assign full = count == FW'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            assert (!(pop && empty));
            assert (!(push && full && !pop));
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + FW'(push) - FW'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch with response buffer and redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to the decoder when the buffer is empty.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic i_clk,
    input logic i_reset,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    fetch_state_e state;
    logic [31:0] fetch_pc, resp_pc, target;
    logic [CW-1:0] live, drop_cnt, total, remain;
    logic [FW-1:0] count;
    logic reset_q, fire, accept, dropping, bypass, push, pop, empty, full, misalign;
    fetch_entry_t head, din;

    // live counts in-flight requests still wanted; drop_cnt counts the older ones to discard
    assign total = live + drop_cnt;
    assign remain = total - CW'(bus.imem_rvalid && total != '0);
    assign target = {bus.redirect_pc[31:2], 2'b00};
    assign bus.imem_req = !i_reset && !bus.redirect && !full
        && (CW'(count) + total < CW'(FIFO_DEPTH)) && (total < CW'(MAX_OUTSTANDING));
    assign bus.imem_addr = fetch_pc;
    assign fire = bus.imem_req && bus.imem_gnt;
    assign dropping = bus.imem_rvalid && drop_cnt != '0;
    assign accept = bus.imem_rvalid && drop_cnt == '0 && !bus.redirect && !i_reset;

`ifdef FETCH_BYPASS_EN
    assign bypass = empty && accept;
`else
    assign bypass = 1'b0;
`endif
    assign push = accept && !(bypass && bus.instr_ready);
    assign pop = !empty && bus.instr_ready;
    assign din = '{pc: resp_pc, instr: bus.imem_rdata};
    assign bus.instr_valid = !empty || bypass;
    assign bus.instr = !empty ? head.instr : bypass ? bus.imem_rdata : '0;
    assign bus.pc = !empty ? head.pc : bypass ? resp_pc : '0;
    assign bus.misalign = misalign;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(i_clk),
        .rst(i_reset),
        .push(push),
        .pop(pop),
        .flush(bus.redirect),
        .din(din),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    // A reset held for more than one cycle clears the drop count: treated as power-on.
    always_ff @(posedge i_clk) begin
        reset_q <= i_reset;
        if (i_reset) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            live <= '0;
            drop_cnt <= reset_q ? '0 : remain;
            state <= RUN;
            misalign <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= target;
            resp_pc <= target;
            live <= '0;
            drop_cnt <= remain;
            state <= remain != '0 ? FLUSH : RUN;
            misalign <= bus.redirect_pc[1:0] != 2'b00;
        end else begin
            assert (state == RUN || drop_cnt != '0);
            if (fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            if (accept) resp_pc <= resp_pc + 32'(INSTR_BYTES);
            live <= live + CW'(fire) - CW'(accept);
            if (dropping) drop_cnt <= drop_cnt - CW'(1);
            if (dropping && drop_cnt == CW'(1)) state <= RUN;
            misalign <= 1'b0;
        end
    end
endmodule
